// File: rtl/axi_bridge_pkg.sv
// Shared AXI bridge types: burst/response encodings, burst FSM states, 4 KB page constant.
// Combinational definitions only; no latency or backpressure of its own.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int PAGE_4K_SHIFT = 12;

endpackage

// File: rtl/axi_next_addr.sv
// Next beat address for FIXED/INCR/WRAP bursts, purely combinational (0 cycles).
// No handshake; the caller decides when to load the result.
module axi_next_addr
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  burst_t            burst,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] stepped;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] wrap_lower;

  always_comb begin
    step       = ADDR_W'(1) << size;
    stepped    = addr + step;
    wrap_bytes = ADDR_W'({1'b0, len} + (LEN_W+1)'(1)) << size;
    wrap_lower = addr & ~(wrap_bytes - ADDR_W'(1));
    next_addr  = addr;
    case (burst)
      // Aligning before the step handles an unaligned first beat of INCR.
      BURST_INCR: next_addr = (addr & ~(step - ADDR_W'(1))) + step;
      BURST_WRAP: next_addr = (stepped == wrap_lower + wrap_bytes) ? wrap_lower : stepped;
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI burst beat address/response generator; first beat 1 cycle after command accept, beats held while beat_ready=0.
// Optional AXI_4K_BOUNDARY_CHECK_EN flags INCR bursts that cross a 4 KB page as SLVERR.
module axi_burst_addr_gen
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 6,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              beat_last,
  output logic [1:0]        beat_resp,
  output logic              busy
);

  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  burst_t            burst_q;
  logic              slverr_q;
  logic [LEN_W:0]    cnt_q;
  logic              cmd_slverr;
  logic              beat_decerr;
  logic [ADDR_W:0]   beat_end;
  burst_t            cmd_burst_e;

  assign cmd_burst_e = burst_t'(cmd_burst);

`ifdef AXI_4K_BOUNDARY_CHECK_EN
  logic [ADDR_W:0] incr_last_byte;
  logic            page_cross;

  always_comb begin
    incr_last_byte = {1'b0, cmd_addr & ~((ADDR_W'(1) << cmd_size) - ADDR_W'(1))}
                   + ((ADDR_W+1)'({1'b0, cmd_len} + (LEN_W+1)'(1)) << cmd_size)
                   - (ADDR_W+1)'(1);
    page_cross = incr_last_byte[ADDR_W:PAGE_4K_SHIFT] != {1'b0, cmd_addr[ADDR_W-1:PAGE_4K_SHIFT]};
  end
`endif

  always_comb begin
    cmd_slverr = 1'b0;
    if (cmd_size > 3'(MAX_SIZE)) cmd_slverr = 1'b1;
    if (cmd_burst_e == BURST_RSVD) cmd_slverr = 1'b1;
    if (cmd_burst_e == BURST_WRAP) begin
      if (!(cmd_len == LEN_W'(1) || cmd_len == LEN_W'(3) ||
            cmd_len == LEN_W'(7) || cmd_len == LEN_W'(15)))
        cmd_slverr = 1'b1;
      if ((cmd_addr & ((ADDR_W'(1) << cmd_size) - ADDR_W'(1))) != '0)
        cmd_slverr = 1'b1;
    end
`ifdef AXI_4K_BOUNDARY_CHECK_EN
    if (cmd_burst_e == BURST_INCR && page_cross) cmd_slverr = 1'b1;
`endif
  end

  // The beat's last byte is >= its first, so one upper-bits test covers both decode rules.
  assign beat_end    = {1'b0, addr_q} + ((ADDR_W+1)'(1) << size_q) - (ADDR_W+1)'(1);
  assign beat_decerr = beat_end[ADDR_W:MEM_AW] != '0;

  axi_next_addr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_next_addr (
    .addr      (addr_q),
    .burst     (burst_q),
    .size      (size_q),
    .len       (len_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = ST_BURST;
      ST_BURST: if (beat_ready && beat_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    beat_valid = (state == ST_BURST);
    busy       = (state == ST_BURST);
    beat_addr  = addr_q;
    beat_last  = (state == ST_BURST) && (cnt_q == {1'b0, len_q});
    beat_resp  = RESP_OKAY;
    if (state == ST_BURST) begin
      if (slverr_q)         beat_resp = RESP_SLVERR;
      else if (beat_decerr) beat_resp = RESP_DECERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
      slverr_q <= 1'b0;
      cnt_q    <= '0;
    end else if (cmd_valid && cmd_ready) begin
      addr_q   <= cmd_addr;
      len_q    <= cmd_len;
      size_q   <= cmd_size;
      burst_q  <= cmd_burst_e;
      slverr_q <= cmd_slverr;
      cnt_q    <= '0;
    end else if (beat_valid && beat_ready) begin
      cnt_q <= beat_last ? '0 : cnt_q + (LEN_W+1)'(1);
      // Erroring bursts keep reporting the command address on every beat.
      if (!slverr_q && !beat_last) addr_q <= next_addr;
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Bench for axi_burst_addr_gen: directed vector table plus random commands against a reference model,
// driving a MEM_AW=6 and a MEM_AW=16 instance with identical stimulus.
module tb_axi_burst_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_ready;

  logic        cmd_ready_a, beat_valid_a, beat_last_a, busy_a;
  logic [31:0] beat_addr_a;
  logic [1:0]  beat_resp_a;
  logic        cmd_ready_b, beat_valid_b, beat_last_b, busy_b;
  logic [31:0] beat_addr_b;
  logic [1:0]  beat_resp_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_burst_addr_gen dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid_a), .beat_ready(beat_ready), .beat_addr(beat_addr_a),
    .beat_last(beat_last_a), .beat_resp(beat_resp_a), .busy(busy_a)
  );

  axi_burst_addr_gen #(.MEM_AW(16)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid_b), .beat_ready(beat_ready), .beat_addr(beat_addr_b),
    .beat_last(beat_last_b), .beat_resp(beat_resp_b), .busy(busy_b)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          mode;
    logic [31:0] ea [4];
    logic [1:0]  er [4];
  } vec_t;

  localparam int NVEC = 11;
  vec_t tab [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3,
                         input logic [1:0] r0, input logic [1:0] r1,
                         input logic [1:0] r2, input logic [1:0] r3);
    tab[i].addr = addr; tab[i].len = len; tab[i].size = size;
    tab[i].burst = burst; tab[i].mode = mode;
    tab[i].ea[0] = a0; tab[i].ea[1] = a1; tab[i].ea[2] = a2; tab[i].ea[3] = a3;
    tab[i].er[0] = r0; tab[i].er[1] = r1; tab[i].er[2] = r2; tab[i].er[3] = r3;
  endtask

  // Reference: address of beat n computed directly from the burst rules; returns {resp, addr}.
  function automatic logic [33:0] model_beat(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int n, input int mem_aw);
    longint unsigned a0, l, bs, w, lower, a, nn;
    bit err;
    a0 = 64'(addr); l = 64'(len); bs = 64'd1 << size; nn = 64'(n);
    err = (size > 3'd2) || (burst == 2'b11) ||
          (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
          (burst == 2'b10 && (a0 % bs) != 0);
`ifdef AXI_4K_BOUNDARY_CHECK_EN
    if (burst == 2'b01 && ((((a0 / bs) * bs + (l + 1) * bs - 1) >> 12) != (a0 >> 12))) err = 1'b1;
`endif
    if (err) return {2'b10, addr};
    a = a0;
    if (burst == 2'b01 && n > 0) a = ((a0 / bs) * bs + nn * bs) % 64'h1_0000_0000;
    if (burst == 2'b10) begin
      w = (l + 1) * bs;
      lower = (a0 / w) * w;
      a = lower + ((a0 - lower) + nn * bs) % w;
    end
    if ((a >> mem_aw) != 0 || (a + bs - 1) >= (64'd1 << mem_aw)) return {2'b11, a[31:0]};
    return {2'b00, a[31:0]};
  endfunction

  // ti >= 0 takes instance A's expectations from the table, otherwise from the model.
  task automatic run_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int mode, input int ti);
    int n, cyc;
    logic [33:0] ea, eb;
    bit rdy;
    @(negedge clk);
    chk("idle_cmd_ready_a", cmd_ready_a, 1);
    chk("idle_beat_valid_a", beat_valid_a, 0);
    chk("idle_cmd_ready_b", cmd_ready_b, 1);
    cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("first_beat_latency", beat_valid_a, 1);
    n = 0; cyc = 0;
    while (n <= int'(len) && cyc < 200) begin
      if (ti >= 0) ea = {tab[ti].er[n], tab[ti].ea[n]};
      else         ea = model_beat(addr, len, size, burst, n, 6);
      eb = model_beat(addr, len, size, burst, n, 16);
      chk("beat_valid_a", beat_valid_a, 1);
      chk("busy_a", busy_a, 1);
      chk("beat_addr_a", beat_addr_a, ea[31:0]);
      chk("beat_resp_a", beat_resp_a, ea[33:32]);
      chk("beat_last_a", beat_last_a, (n == int'(len)));
      chk("beat_valid_b", beat_valid_b, 1);
      chk("beat_addr_b", beat_addr_b, eb[31:0]);
      chk("beat_resp_b", beat_resp_b, eb[33:32]);
      chk("beat_last_b", beat_last_b, (n == int'(len)));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      beat_ready = rdy;
      @(negedge clk);
      if (rdy) n++;
      cyc++;
    end
    beat_ready = 1'b0;
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", n, int'(len) + 1);
    end
    chk("done_cmd_ready_a", cmd_ready_a, 1);
    chk("done_beat_valid_a", beat_valid_a, 0);
    chk("done_busy_a", busy_a, 0);
  endtask

  initial begin
    logic [1:0] rb;
    logic [2:0] rs;
    logic [7:0] rl;
    logic [31:0] ra;

    set_vec(0,  32'h04, 8'd3, 3'd2, 2'b01, 0, 32'h04, 32'h08, 32'h0C, 32'h10, 2'b00, 2'b00, 2'b00, 2'b00);
    set_vec(1,  32'h38, 8'd3, 3'd2, 2'b10, 2, 32'h38, 32'h3C, 32'h30, 32'h34, 2'b00, 2'b00, 2'b00, 2'b00);
    set_vec(2,  32'h38, 8'd2, 3'd2, 2'b10, 0, 32'h38, 32'h38, 32'h38, 32'h0,  2'b10, 2'b10, 2'b10, 2'b00);
    set_vec(3,  32'h10, 8'd2, 3'd2, 2'b00, 1, 32'h10, 32'h10, 32'h10, 32'h0,  2'b00, 2'b00, 2'b00, 2'b00);
    set_vec(4,  32'h3C, 8'd1, 3'd2, 2'b01, 0, 32'h3C, 32'h40, 32'h0,  32'h0,  2'b00, 2'b11, 2'b00, 2'b00);
    set_vec(5,  32'h3C, 8'd1, 3'd3, 2'b01, 0, 32'h3C, 32'h3C, 32'h0,  32'h0,  2'b10, 2'b10, 2'b00, 2'b00);
    set_vec(6,  32'h08, 8'd1, 3'd2, 2'b11, 1, 32'h08, 32'h08, 32'h0,  32'h0,  2'b10, 2'b10, 2'b00, 2'b00);
    set_vec(7,  32'h3A, 8'd3, 3'd2, 2'b10, 0, 32'h3A, 32'h3A, 32'h3A, 32'h3A, 2'b10, 2'b10, 2'b10, 2'b10);
    set_vec(8,  32'h05, 8'd2, 3'd2, 2'b01, 2, 32'h05, 32'h08, 32'h0C, 32'h0,  2'b00, 2'b00, 2'b00, 2'b00);
    set_vec(9,  32'h21, 8'd1, 3'd0, 2'b10, 0, 32'h21, 32'h20, 32'h0,  32'h0,  2'b00, 2'b00, 2'b00, 2'b00);
`ifdef AXI_4K_BOUNDARY_CHECK_EN
    set_vec(10, 32'hFF8, 8'd3, 3'd2, 2'b01, 0, 32'hFF8, 32'hFF8, 32'hFF8, 32'hFF8, 2'b10, 2'b10, 2'b10, 2'b10);
`else
    set_vec(10, 32'hFF8, 8'd3, 3'd2, 2'b01, 0, 32'hFF8, 32'hFFC, 32'h1000, 32'h1004, 2'b11, 2'b11, 2'b11, 2'b11);
`endif

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    cmd_burst = '0; beat_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready_a, 1);
    chk("rst_beat_valid", beat_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_beat_addr", beat_addr_a, 0);
    chk("rst_beat_resp", beat_resp_a, 0);
    chk("rst_beat_last", beat_last_a, 0);

    for (int i = 0; i < NVEC; i++)
      run_cmd(tab[i].addr, tab[i].len, tab[i].size, tab[i].burst, tab[i].mode, i);

    // Reset while the second of four beats is on the bus.
    @(negedge clk);
    cmd_addr = 32'h0; cmd_len = 8'd3; cmd_size = 3'd2; cmd_burst = 2'b01; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; beat_ready = 1'b1;
    @(negedge clk);
    chk("midrst_beat2_addr", beat_addr_a, 32'h4);
    reset = 1'b1; beat_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_cmd_ready", cmd_ready_a, 1);
    chk("midrst_beat_valid", beat_valid_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_beat_last", beat_last_a, 0);
    chk("midrst_beat_resp", beat_resp_a, 0);
    chk("midrst_beat_addr", beat_addr_a, 0);
    run_cmd(tab[0].addr, tab[0].len, tab[0].size, tab[0].burst, 0, 0);

    for (int k = 0; k < 60; k++) begin
      rb = 2'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 3));
      if (rb == 2'b10) begin
        case ($urandom_range(0, 4))
          0:       rl = 8'd1;
          1:       rl = 8'd2;
          2:       rl = 8'd3;
          3:       rl = 8'd7;
          default: rl = 8'd15;
        endcase
      end else begin
        rl = 8'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0) ra = 32'h0FF0 + 32'($urandom_range(0, 31));
      else                           ra = 32'($urandom_range(0, 127));
      if (rb == 2'b10 && $urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
      run_cmd(ra, rl, rs, rb, $urandom_range(0, 2), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_addr_gen.md
AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data bus width in bits (8..1024, power of two).
REQ-003 SHALL have parameter MEM_AW, default 6, decoded slave byte-address width; the slave spans 0 .. 2^MEM_AW-1.
REQ-004 SHALL have parameter LEN_W, default 8, AxLEN width.
REQ-005 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset (one clock, sync active-high, fixed).
REQ-006 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_addr in ADDR_W start address; cmd_len in LEN_W beats-1; cmd_size in 3 log2 bytes/beat; cmd_burst in 2 (00 FIXED, 01 INCR, 10 WRAP, 11 reserved).
REQ-007 SHALL have beat ports: beat_valid out 1; beat_ready in 1; beat_addr out ADDR_W; beat_last out 1; beat_resp out 2 (00 OKAY, 10 SLVERR, 11 DECERR); busy out 1.

Function
REQ-008 SHALL implement states IDLE, BURST; IDLE: cmd_ready=1, beat_valid=0.
REQ-009 SHALL latch the command on cmd_valid&cmd_ready, go to BURST, and assert beat_valid on the next cycle (1-cycle latency).
REQ-010 SHALL hold beat_addr/beat_last/beat_resp stable while beat_valid&!beat_ready; advance only on beat_valid&beat_ready.
REQ-011 SHALL emit exactly cmd_len+1 beats; beat_last=1 only on the final beat; counter LEN_W+1 bits.
REQ-012 SHALL, after final-beat handshake, return to IDLE; cmd_ready=1 the following cycle (no command overlap).
REQ-013 SHALL address FIXED: every beat = cmd_addr.
REQ-014 SHALL address INCR: beat0 = cmd_addr; beat n = (cmd_addr aligned down to 2^size) + n*2^size, modulo 2^ADDR_W.
REQ-015 SHALL address WRAP: W=(len+1)*2^size; lower=cmd_addr & ~(W-1); next=addr+2^size, replaced by lower when it equals lower+W.
REQ-016 SHALL flag SLVERR on all beats when: size > log2(DATA_W/8); burst=11; WRAP with len not in {1,3,7,15}; WRAP with cmd_addr not 2^size-aligned.
REQ-017 SHALL flag DECERR per beat when that beat_addr[ADDR_W-1:MEM_AW] != 0 or beat_addr+2^size-1 exceeds 2^MEM_AW-1; SLVERR takes priority over DECERR.
REQ-018 SHALL, on any error, still emit len+1 beats with beat_addr held at cmd_addr.
REQ-019 SHALL drive busy=1 in BURST.

Reset
REQ-020 SHALL, on reset (any state, incl. mid-burst), enter IDLE next edge: cmd_ready=1, beat_valid=0, beat_last=0, beat_resp=00, beat_addr=0, busy=0, counter=0; partial burst abandoned.

Configuration
REQ-021 SHALL, with AXI_4K_BOUNDARY_CHECK_EN defined, flag SLVERR on all beats of an INCR burst whose last byte lies in a different 4 KB page than cmd_addr.
REQ-022 SHALL, without AXI_4K_BOUNDARY_CHECK_EN, perform no 4 KB check.

Structure
REQ-023 SHALL take burst_t (FIXED/INCR/WRAP/RSVD), resp_t (OKAY/EXOKAY/SLVERR/DECERR) and 4 KB page constant from shared package axi_bridge_pkg.
REQ-024 SHALL place next-address arithmetic (REQ-013..015) in one combinational sub-module axi_next_addr.

Verification (DATA_W=32, MEM_AW=6 unless noted)
REQ-025 SHALL cover INCR addr 0x04 len 3 size 2 -> beats 0x04,0x08,0x0C,0x10, last on 4th, all OKAY.
REQ-026 SHALL cover WRAP addr 0x38 len 3 size 2 -> 0x38,0x3C,0x30,0x34; and WRAP len 2 -> 3 beats SLVERR.
REQ-027 SHALL cover FIXED addr 0x10 len 2, beat_ready toggling 1/0 -> three beats 0x10, outputs stable during stalls.
REQ-028 SHALL cover INCR addr 0x3C len 1 size 2 -> 0x3C OKAY, 0x40 DECERR; size 3 or burst 11 -> len+1 beats SLVERR.
REQ-029 SHALL cover reset asserted on beat 2 of 4 -> IDLE next cycle, cmd_ready=1, next command starts clean.
REQ-030 SHALL cover MEM_AW=16, macro on: INCR addr 0x0FF8 len 3 size 2 -> 4 beats SLVERR; macro off -> OKAY.
